// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MEM stage.
//   WD_SEL_*     : writeback source select encodings carried by mem_wD_sel
//   RD_MSB/LSB   : destination-register field bounds inside the instruction word
//   lsu_state_e  : load/store unit bus FSM state encoding
package pipe_pkg;

    localparam logic [1:0] WD_SEL_ALU  = 2'b00;
    localparam logic [1:0] WD_SEL_DRAM = 2'b01;
    localparam logic [1:0] WD_SEL_PC4  = 2'b10;

    localparam int RD_MSB = 11;
    localparam int RD_LSB = 7;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/mem_bus_fsm.sv
// Data-memory bus sequencer for the MEM stage.
// Holds the request registers, the timeout down-counter, the read-data latch and
// the abort / sticky error flags.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; a memory op latches its request here
// REQ   | dm_req high, waiting for dm_ack or the timeout counter to expire
// RESP  | access finished (ack or abort); the instruction retires this cycle
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   start                 a memory instruction is waiting in EX/MEM
//   addr, wdata, we       request fields captured when leaving IDLE
//   dm_ack, dm_rdata      responder handshake / read data
//   dm_req, dm_we,
//   dm_addr, dm_wdata     registered bus request
//   dm_err                sticky timeout flag
//   resp                  FSM is in RESP
//   abort                 the access being retired timed out
//   rdata                 latched read data
module mem_bus_fsm
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_err,
    output logic        resp,
    output logic        abort,
    output logic [31:0] rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);

    lsu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             tc;

    // Down-counter is loaded with TIMEOUT-1 on entry to REQ, so terminal count
    // is reached on the TIMEOUT-th REQ cycle.
    assign tc   = (cnt == '0);
    assign resp = (state == LSU_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LSU_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LSU_IDLE: if (start)       state_next = LSU_REQ;
            LSU_REQ:  if (dm_ack || tc) state_next = LSU_RESP;
            LSU_RESP:                  state_next = LSU_IDLE;
            default:                   state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_err   <= 1'b0;
            abort    <= 1'b0;
            rdata    <= '0;
        end else begin
            dm_req <= (state_next == LSU_REQ);
            case (state)
                LSU_IDLE: begin
                    if (start) begin
                        dm_addr  <= addr;
                        dm_wdata <= wdata;
                        dm_we    <= we;
                        cnt      <= CNT_W'(TIMEOUT - 1);
                        abort    <= 1'b0;
                    end
                end
                LSU_REQ: begin
                    // An ack arriving on the expiry edge still counts as completion.
                    if (dm_ack) begin
                        if (!dm_we) rdata <= dm_rdata;
                    end else if (tc) begin
                        abort  <= 1'b1;
                        dm_err <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                LSU_RESP: abort <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: drives the data-memory bus for loads/stores, stalls the
// upstream pipeline while an access is in flight, selects the writeback value
// and registers the result into MEM/WB.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   mem_*                           EX/MEM register outputs
//   mem_stall                       hold upstream stages this cycle
//   dm_req/we/addr/wdata/ack/rdata  data-memory bus
//   dm_err                          sticky access-timeout flag
//   wb_*                            MEM/WB register outputs
module mem_stage_lsu
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_pc4,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rD2,
    input  logic [1:0]  mem_wD_sel,
    input  logic        mem_DRAM_we,
    input  logic        mem_RF_WE,
    output logic        mem_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        wb_valid,
    output logic [31:0] wb_inst,
    output logic [4:0]  wb_rd,
    output logic        wb_RF_WE,
    output logic [31:0] wb_wD
);

    logic        is_mem;
    logic        resp;
    logic        abort;
    logic [31:0] rdata;
    logic [31:0] wd_next;

    assign is_mem    = mem_valid & (mem_DRAM_we | (mem_wD_sel == WD_SEL_DRAM));
    assign mem_stall = is_mem & ~resp;

    mem_bus_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (is_mem),
        .addr     (mem_alu_result),
        .wdata    (mem_rD2),
        .we       (mem_DRAM_we),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_err   (dm_err),
        .resp     (resp),
        .abort    (abort),
        .rdata    (rdata)
    );

    // abort is only ever set while RESP is active, so non-memory ops see 0.
    always_comb begin
        wd_next = mem_alu_result;
        case (mem_wD_sel)
            WD_SEL_DRAM: wd_next = abort ? 32'h0 : rdata;
            WD_SEL_PC4:  wd_next = mem_pc4;
            default:     wd_next = mem_alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_inst  <= '0;
            wb_rd    <= '0;
            wb_RF_WE <= 1'b0;
            wb_wD    <= '0;
        end else if (mem_stall || !mem_valid) begin
            wb_valid <= 1'b0;
            wb_RF_WE <= 1'b0;
        end else begin
            wb_valid <= 1'b1;
            wb_inst  <= mem_inst;
            wb_rd    <= mem_inst[RD_MSB:RD_LSB];
            wb_RF_WE <= mem_RF_WE & ~abort;
            wb_wD    <= wd_next;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_inst = '0;
    logic [31:0] mem_pc4 = '0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_rD2 = '0;
    logic [1:0]  mem_wD_sel = '0;
    logic        mem_DRAM_we = 1'b0;
    logic        mem_RF_WE = 1'b0;
    logic        mem_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        dm_err;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic [4:0]  wb_rd;
    logic        wb_RF_WE;
    logic [31:0] wb_wD;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_inst(mem_inst), .mem_pc4(mem_pc4),
        .mem_alu_result(mem_alu_result), .mem_rD2(mem_rD2), .mem_wD_sel(mem_wD_sel),
        .mem_DRAM_we(mem_DRAM_we), .mem_RF_WE(mem_RF_WE), .mem_stall(mem_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_rd(wb_rd),
        .wb_RF_WE(wb_RF_WE), .wb_wD(wb_wD)
    );

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rfwe;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   retired = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every retirement seen on MEM/WB is matched in order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid) begin
                retired++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", {31'b0, wb_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_inst", wb_inst, e.inst);
                    chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                    chk("wb_RF_WE", {31'b0, wb_RF_WE}, {31'b0, e.rfwe});
                    chk("wb_wD", wb_wD, e.wd);
                end
            end
        end
    end

    function automatic logic [31:0] mk_inst(input logic [4:0] rd);
        return {20'h12345, rd, 7'h13};
    endfunction

    // Called just after a rising edge. Presents one instruction, answers the bus
    // with dm_ack on REQ cycle ack_at (0 = never) and holds it until it retires.
    task automatic run_op(input logic [4:0] rd, input logic [31:0] pc4, alu, rd2,
                          input logic [1:0] sel, input logic we, rfwe,
                          input int ack_at, input logic [31:0] rdata,
                          output int stall_cyc, output int req_cyc,
                          output logic saw_we, output logic [31:0] saw_addr, saw_wdata);
        logic st;
        stall_cyc = 0; req_cyc = 0; saw_we = 0; saw_addr = '0; saw_wdata = '0;
        mem_valid = 1; mem_inst = mk_inst(rd); mem_pc4 = pc4; mem_alu_result = alu;
        mem_rD2 = rd2; mem_wD_sel = sel; mem_DRAM_we = we; mem_RF_WE = rfwe;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dm_req) begin
                req_cyc++;
                saw_we = dm_we; saw_addr = dm_addr; saw_wdata = dm_wdata;
                if (req_cyc == ack_at) begin
                    dm_ack = 1; dm_rdata = rdata;
                end
            end
            st = mem_stall;
            if (st) stall_cyc++;
            @(posedge clk); #1;
            dm_ack = 0; dm_rdata = 32'hBAD0_BAD0;
            if (!st) break;
            if (i == 199) chk("op_timeout_budget", 32'd1, {31'b0, mem_stall} ^ 32'd1);
        end
        mem_valid = 0;
    endtask

    function automatic exp_t mk_exp(input logic [4:0] rd, input logic rfwe, input logic [31:0] wd);
        exp_t e;
        e.inst = mk_inst(rd); e.rd = rd; e.rfwe = rfwe; e.wd = wd;
        return e;
    endfunction

    initial begin
        int sc, rc;
        logic sw;
        logic [31:0] sa, sd;

        // Reset state
        #12;
        chk("rst_dm_req", {31'b0, dm_req}, 32'h0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst_dm_err", {31'b0, dm_err}, 32'h0);
        chk("rst_wb_wD", wb_wD, 32'h0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // 1: ALU op
        exp_q.push_back(mk_exp(5'd3, 1'b1, 32'h1234));
        run_op(5'd3, 32'h8, 32'h1234, 32'h0, 2'b00, 1'b0, 1'b1, 0, 32'h0, sc, rc, sw, sa, sd);
        chk("alu_stall", sc, 0);
        chk("alu_req", rc, 0);

        // 2: load, ack in 3rd REQ cycle
        exp_q.push_back(mk_exp(5'd7, 1'b1, 32'hDEADBEEF));
        run_op(5'd7, 32'h10, 32'h100, 32'h0, 2'b01, 1'b0, 1'b1, 3, 32'hDEADBEEF, sc, rc, sw, sa, sd);
        chk("ld_stall", sc, 4);
        chk("ld_req", rc, 3);
        chk("ld_addr", sa, 32'h100);
        chk("ld_we", {31'b0, sw}, 32'h0);

        // 3: store, ack in 1st REQ cycle
        exp_q.push_back(mk_exp(5'd0, 1'b0, 32'h200));
        run_op(5'd0, 32'h14, 32'h200, 32'hA5A5A5A5, 2'b00, 1'b1, 1'b0, 1, 32'h0, sc, rc, sw, sa, sd);
        chk("st_stall", sc, 2);
        chk("st_req", rc, 1);
        chk("st_we", {31'b0, sw}, 32'h1);
        chk("st_addr", sa, 32'h200);
        chk("st_wdata", sd, 32'hA5A5A5A5);

        // Ack on the same edge the timeout would fire: normal completion
        exp_q.push_back(mk_exp(5'd9, 1'b1, 32'hCAFE0001));
        run_op(5'd9, 32'h18, 32'h300, 32'h0, 2'b01, 1'b0, 1'b1, 8, 32'hCAFE0001, sc, rc, sw, sa, sd);
        chk("edge_ack_req", rc, 8);
        chk("edge_ack_err", {31'b0, dm_err}, 32'h0);

        // 4: load with no ack -> timeout abort
        exp_q.push_back(mk_exp(5'd11, 1'b0, 32'h0));
        run_op(5'd11, 32'h1C, 32'h400, 32'h0, 2'b01, 1'b0, 1'b1, 0, 32'h0, sc, rc, sw, sa, sd);
        chk("to_req", rc, 8);
        chk("to_stall", sc, 9);
        chk("to_err", {31'b0, dm_err}, 32'h1);
        exp_q.push_back(mk_exp(5'd12, 1'b1, 32'h5555));
        run_op(5'd12, 32'h20, 32'h5555, 32'h0, 2'b11, 1'b0, 1'b1, 0, 32'h0, sc, rc, sw, sa, sd);
        chk("after_to_stall", sc, 0);
        @(negedge clk);
        chk("err_sticky", {31'b0, dm_err}, 32'h1);

        // 5: reset during REQ
        mem_valid = 1; mem_inst = mk_inst(5'd13); mem_alu_result = 32'h500;
        mem_wD_sel = 2'b01; mem_DRAM_we = 0; mem_RF_WE = 1;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_req", {31'b0, dm_req}, 32'h1);
        #2 rst_n = 0; #1;
        chk("arst_dm_req", {31'b0, dm_req}, 32'h0);
        chk("arst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("arst_wb_RF_WE", {31'b0, wb_RF_WE}, 32'h0);
        chk("arst_wb_wD", wb_wD, 32'h0);
        chk("arst_wb_inst", wb_inst, 32'h0);
        chk("arst_dm_err", {31'b0, dm_err}, 32'h0);
        mem_valid = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        exp_q.push_back(mk_exp(5'd14, 1'b1, 32'h0BADF00D));
        run_op(5'd14, 32'h24, 32'h600, 32'h0, 2'b01, 1'b0, 1'b1, 2, 32'h0BADF00D, sc, rc, sw, sa, sd);
        chk("post_rst_req", rc, 2);

        // 6: PC+4 select, then a bubble
        exp_q.push_back(mk_exp(5'd1, 1'b1, 32'h44));
        run_op(5'd1, 32'h44, 32'h9999, 32'h0, 2'b10, 1'b0, 1'b1, 0, 32'h0, sc, rc, sw, sa, sd);
        mem_wD_sel = 2'b01; mem_DRAM_we = 1; mem_RF_WE = 1; mem_valid = 0;
        @(negedge clk);
        chk("bubble_stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        chk("bubble_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("bubble_wb_RF_WE", {31'b0, wb_RF_WE}, 32'h0);
        chk("bubble_dm_req", {31'b0, dm_req}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("retire_count", retired, 8);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hung, expected finish");
        $fatal(1);
    end

endmodule
